ula_reg_bank_slv: RTL and testbench

- Slave-side responder for the ULA/register-bank bus.
- Holds a bank of 2^ADDR_W registers, each DATA_W bits wide, written through valid_reg/addr/data_in.
- Executes ALU ops on input A and bank register reg_sel, selected by instru, when valid_ula is asserted.
- Returns a registered 2*DATA_W-bit result on data_out, qualified by a one-cycle valid_out pulse.
- Drives the slave modport outputs for the master stimulus agent.

---
 rtl/ula_reg_bank_slv.sv | 120 ++++++++++++
 tb/tb_ula_reg_bank_slv.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_reg_bank_slv.sv
// rtl/ula_reg_bank_slv.sv - ULA/register-bank slave: register bank plus iterative ALU responder
module ula_reg_bank_slv #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic                clk_ula,
  input  logic                rst,
  input  logic                valid_reg,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                valid_ula,
  input  logic [DATA_W-1:0]   A,
  input  logic [ADDR_W-1:0]   reg_sel,
  input  logic [1:0]          instru,
  output logic [2*DATA_W-1:0] data_out,
  output logic                valid_out,
  output logic                busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  logic [DATA_W-1:0] bank_q [DEPTH];
  state_t            state_q;
  logic [1:0]        op_q;
  // opa_q is the zero-extended operand A; during MUL it is the left-shifting multiplicand.
  logic [RES_W-1:0]  opa_q;
  // opb_q is operand B; during MUL it is the right-shifting multiplier.
  logic [DATA_W-1:0] opb_q;
  logic [RES_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [RES_W-1:0]  opb_ext;
  logic [RES_W-1:0]  partial_d;
  logic [RES_W-1:0]  acc_d;
  logic [RES_W-1:0]  single_res_d;
  logic              last_step_d;

  // Shift-add step for MUL and the single-cycle results for the other ops.
  always_comb begin
    opb_ext      = {{DATA_W{1'b0}}, opb_q};
    partial_d    = opb_q[0] ? opa_q : '0;
    acc_d        = acc_q + partial_d;
    last_step_d  = (cnt_q == CNT_W'(DATA_W - 1));
    single_res_d = '0;
    case (op_q)
      OP_ADD:  single_res_d = opa_q + opb_ext;
      OP_SUB:  single_res_d = opa_q - opb_ext;
      OP_AND:  single_res_d = opa_q & opb_ext;
      default: single_res_d = acc_d;
    endcase
  end

  // Register bank: writes land in any FSM state; reads by the FSM see the pre-write value.
  always_ff @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (valid_reg) begin
      bank_q[addr] <= data_in;
    end
  end

  // Operation FSM: capture in IDLE, execute, publish a registered result with a one-cycle valid.
  always_ff @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_ula) begin
            opa_q   <= {{DATA_W{1'b0}}, A};
            opb_q   <= bank_q[reg_sel];
            op_q    <= instru;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (op_q != OP_MUL || last_step_d) begin
            data_out  <= (op_q == OP_MUL) ? acc_d : single_res_d;
            valid_out <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end else begin
            acc_q <= acc_d;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_reg_bank_slv.sv
// tb/tb_ula_reg_bank_slv.sv - scoreboard bench for ula_reg_bank_slv
module tb_ula_reg_bank_slv;

  localparam int DW = 16;
  localparam int AW = 2;

  logic            clk_ula = 1'b0;
  logic            rst = 1'b0;
  logic            valid_reg = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   data_in = '0;
  logic            valid_ula = 1'b0;
  logic [DW-1:0]   a_in = '0;
  logic [AW-1:0]   reg_sel = '0;
  logic [1:0]      instru = '0;
  logic [2*DW-1:0] data_out;
  logic            valid_out;
  logic            busy;

  ula_reg_bank_slv #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_ula   (clk_ula),
    .rst       (rst),
    .valid_reg (valid_reg),
    .addr      (addr),
    .data_in   (data_in),
    .valid_ula (valid_ula),
    .A         (a_in),
    .reg_sel   (reg_sel),
    .instru    (instru),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy)
  );

  always #5 clk_ula = ~clk_ula;

  typedef struct {
    logic [2*DW-1:0] res;
    int              due;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] mbank [1<<AW];
  int            m_rem = 0;
  logic          exp_busy = 1'b0;
  int            edge_n = 0;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [2*DW-1:0] ref_alu(input logic [1:0] op, input logic [DW-1:0] x,
                                              input logic [DW-1:0] y);
    logic [2*DW-1:0] xe, ye;
    xe = {{DW{1'b0}}, x};
    ye = {{DW{1'b0}}, y};
    case (op)
      2'b00:   return xe + ye;
      2'b01:   return xe - ye;
      2'b10:   return xe * ye;
      default: return xe & ye;
    endcase
  endfunction

  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < (1 << AW); i++) mbank[i] = '0;
    m_rem    = 0;
    exp_busy = 1'b0;
  endtask

  // Reference behaviour of one rising edge, using the inputs that were held across it.
  task automatic model_edge();
    exp_t e;
    if (!rst) return;
    if (m_rem > 0) begin
      m_rem--;
    end else if (valid_ula) begin
      e.res = ref_alu(instru, a_in, mbank[reg_sel]);
      m_rem = (instru == 2'b10) ? DW : 1;
      e.due = edge_n + m_rem;
      sb_q.push_back(e);
    end
    if (valid_reg) mbank[addr] = data_in;
    exp_busy = (m_rem > 0);
  endtask

  task automatic tick();
    @(posedge clk_ula);
    #2;
    edge_n++;
    model_edge();
  endtask

  task automatic drive(input logic vr, input logic [AW-1:0] ad, input logic [DW-1:0] di,
                       input logic vu, input logic [DW-1:0] av, input logic [AW-1:0] sel,
                       input logic [1:0] op);
    tick();
    valid_reg = vr;
    addr      = ad;
    data_in   = di;
    valid_ula = vu;
    a_in      = av;
    reg_sel   = sel;
    instru    = op;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'b00);
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] di);
    drive(1'b1, ad, di, 1'b0, '0, '0, 2'b00);
  endtask

  task automatic op(input logic [DW-1:0] av, input logic [AW-1:0] sel, input logic [1:0] code);
    drive(1'b0, '0, '0, 1'b1, av, sel, code);
  endtask

  task automatic wait_idle();
    idle();
    for (int i = 0; i < 40 && m_rem > 0; i++) idle();
  endtask

  task automatic check_dout(input logic [2*DW-1:0] req, input string name);
    n_vec++;
    if (data_out !== req) begin
      n_err++;
      $display("FAIL %s: data_out=%h required=%h", name, data_out, req);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_vec++;
    if (data_out !== '0 || valid_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: data_out=%h valid_out=%b busy=%b required 0/0/0", name, data_out,
               valid_out, busy);
    end
  endtask

  // Monitor: every live cycle, check busy and match valid_out pulses against the scoreboard.
  always @(negedge clk_ula) begin
    if (rst) begin
      n_vec++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL busy at edge %0d: got %b required %b", edge_n, busy, exp_busy);
      end
      if (valid_out === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected valid_out at edge %0d: data_out=%h required no response",
                   edge_n, data_out);
        end else begin
          if (data_out !== sb_q[0].res || sb_q[0].due != edge_n) begin
            n_err++;
            $display("FAIL result: data_out=%h at edge %0d required %h at edge %0d", data_out,
                     edge_n, sb_q[0].res, sb_q[0].due);
          end
          void'(sb_q.pop_front());
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= edge_n) begin
        n_vec++;
        n_err++;
        $display("FAIL missing valid_out: edge %0d got none, required %h due at edge %0d",
                 edge_n, sb_q[0].res, sb_q[0].due);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #3;
    check_zero_outputs("reset_outputs");
    repeat (2) @(posedge clk_ula);
    #2;
    rst = 1'b1;
    repeat (3) idle();
    check_zero_outputs("idle_after_reset");

    // Bank was cleared, so reg_sel=0 contributes 0.
    op(16'h0005, 2'd0, 2'b00);
    wait_idle();
    check_dout(32'h0000_0005, "add_reset_bank");

    // Carry into bit DATA_W.
    wr(2'd1, 16'h00FF);
    op(16'hFF01, 2'd1, 2'b00);
    wait_idle();
    check_dout(32'h0001_0000, "add_carry");

    wr(2'd2, 16'h0005);
    op(16'h0003, 2'd2, 2'b01);
    wait_idle();
    check_dout(32'hFFFF_FFFE, "sub_negative");

    wr(2'd3, 16'hFFFF);
    op(16'hFFFF, 2'd3, 2'b10);
    wait_idle();
    check_dout(32'hFFFE_0001, "mul_max");

    // Same-edge write and request: operand B is the pre-write value.
    wr(2'd0, 16'h0002);
    drive(1'b1, 2'd0, 16'h0007, 1'b1, 16'h0001, 2'd0, 2'b00);
    wait_idle();
    check_dout(32'h0000_0003, "read_before_write");
    op(16'h0000, 2'd0, 2'b00);
    wait_idle();
    check_dout(32'h0000_0007, "write_landed");

    // Requests during a MUL, including on its result edge, are dropped.
    op(16'h1234, 2'd2, 2'b10);
    repeat (2) idle();
    op(16'h1111, 2'd1, 2'b00);
    repeat (12) idle();
    op(16'h2222, 2'd1, 2'b00);
    repeat (3) idle();
    check_dout(32'h0000_1234 * 32'h5, "mul_with_drops");

    // Reset in the middle of a MUL aborts it and clears the bank.
    wr(2'd0, 16'h00FF);
    op(16'hABCD, 2'd3, 2'b10);
    repeat (8) idle();
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("async_reset_mid_mul");
    repeat (3) idle();
    rst = 1'b1;
    idle();
    op(16'hF0F0, 2'd0, 2'b11);
    wait_idle();
    check_dout(32'h0000_0000, "and_after_reset");

    // Randomized traffic with writes and requests interleaved freely.
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] ra, rd;
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : DW'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 16'hFFFF : DW'($urandom);
      drive(($urandom_range(0, 2) == 0), AW'($urandom), rd, ($urandom_range(0, 2) == 0), ra,
            AW'($urandom), 2'($urandom));
    end
    wait_idle();
    repeat (3) idle();

    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
